// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and the opcode constants decoded by MainControl.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch unit: jump beats taken branch beats sequential.
module next_pc_logic (
  input  logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] next_pc
);

  logic signed [31:0] boff_ext;
  logic        [31:0] jump_target;
  logic        [31:0] branch_target;

  // Word offset becomes a byte offset; the add wraps modulo 2^32.
  assign boff_ext      = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign branch_target = pc_plus4 + $unsigned(boff_ext);
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = jump_target;
    else if (branch_taken)
      next_pc = branch_target;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding read, holds the fetched word until decode accepts it.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = OP_HALT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic        halted
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_p0;
  logic [31:0]  instr_p1;
  logic [31:0]  pc_p1;
  logic [31:0]  next_pc;
  logic         accept;
  logic         handshake;

  assign accept    = (state == FETCH) && imem_ack;
  assign handshake = (state == HOLD) && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= FETCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        // State already reads FETCH during reset; keep the bus quiet until release.
        imem_req = ~reset;
        if (imem_ack)
          state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready)
          state_nxt = (op == HALT_OP) ? HALT : FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  // Stage p0: fetch address; stage p1: held instruction and its address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0    <= RESET_PC;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else if (accept) begin
      instr_p1 <= imem_rdata;
      pc_p1    <= pc_p0;
    end else if (handshake) begin
      pc_p0    <= next_pc;
    end
  end

  next_pc_logic u_next_pc (
    .pc_plus4      (pc_plus4),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc       (next_pc)
  );

  assign imem_addr = pc_p0;
  assign instr     = instr_p1;
  assign op        = instr_p1[31:26];
  assign pc_out    = pc_p1;
  assign pc_plus4  = pc_p1 + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed fetch addresses and held values.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        halted;

  int passed = 0;
  int total  = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .op            (op),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for a request, checks its address, acks it with data, checks the held result.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (imem_req !== 1'b1) $display("FAIL fetch_req @%h: req=%b want 1", addr, imem_req);
    else passed++;
    total++;
    if (imem_addr !== addr) $display("FAIL fetch_addr: got %h want %h", imem_addr, addr);
    else passed++;
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    total++;
    if (instr_valid !== 1'b1 || instr !== data || pc_out !== addr || imem_req !== 1'b0)
      $display("FAIL fetch_hold @%h: valid=%b instr=%h pc_out=%h req=%b want 1 %h %h 0",
               addr, instr_valid, instr, pc_out, imem_req, data, addr);
    else passed++;
  endtask

  // One-cycle handshake with the given redirect inputs; checks the next request address.
  task automatic handshake(input logic j, input logic [25:0] idx, input logic bt,
                           input logic [15:0] off, input logic [31:0] next_addr);
    instr_ready   = 1'b1;
    jump          = j;
    jump_index    = idx;
    branch_taken  = bt;
    branch_offset = off;
    @(negedge clk);
    instr_ready   = 1'b0;
    jump          = 1'b0;
    jump_index    = '0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== next_addr || instr_valid !== 1'b0)
      $display("FAIL handshake_next: req=%b addr=%h valid=%b want 1 %h 0",
               imem_req, imem_addr, instr_valid, next_addr);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 ||
        instr !== 32'h0 || pc_out !== 32'h0)
      $display("FAIL reset_state: req=%b valid=%b halted=%b instr=%h pc_out=%h want 0 0 0 0 0",
               imem_req, instr_valid, halted, instr, pc_out);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL reset_first_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    else passed++;
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL req_stable: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    else passed++;
    fetch(32'h0000_0000, 32'h8C01_0004);
    total++;
    if (op !== 6'b100011 || pc_plus4 !== 32'h4)
      $display("FAIL first_op: op=%b pc_plus4=%h want 100011 00000004", op, pc_plus4);
    else passed++;
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      jump       = 1'b1;
      jump_index = 26'h3FF_FFFF;
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(negedge clk);
      total++;
      if (instr !== 32'h8C01_0004 || op !== 6'b100011 || pc_out !== 32'h0 ||
          imem_req !== 1'b0 || instr_valid !== 1'b1)
        $display("FAIL hold_stall[%0d]: instr=%h op=%b pc_out=%h req=%b valid=%b want 8c010004 100011 0 0 1",
                 i, instr, op, pc_out, imem_req, instr_valid);
      else passed++;
    end
    imem_ack   = 1'b0;
    jump       = 1'b0;
    jump_index = '0;
    handshake(1'b0, 26'h0, 1'b0, 16'h0, 32'h0000_0004);
  endtask

  task automatic test_branch_forward();
    fetch(32'h0000_0004, 32'h1000_0002);
    handshake(1'b0, 26'h0, 1'b1, 16'h0002, 32'h0000_0010);
  endtask

  task automatic test_jump();
    fetch(32'h0000_0010, 32'h0800_0040);
    handshake(1'b1, 26'h40, 1'b0, 16'h0, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h0800_0008);
    handshake(1'b1, 26'h8, 1'b0, 16'h0, 32'h0000_0020);
  endtask

  task automatic test_branch_back();
    fetch(32'h0000_0020, 32'h1000_FFFE);
    handshake(1'b0, 26'h0, 1'b1, 16'hFFFE, 32'h0000_001C);
    fetch(32'h0000_001C, 32'h0000_0000);
    handshake(1'b0, 26'h0, 1'b1, 16'h0000, 32'h0000_0020);
    fetch(32'h0000_0020, 32'h1000_FFFE);
    handshake(1'b1, 26'h100, 1'b1, 16'hFFFE, 32'h0000_0400);
  endtask

  task automatic test_reset_mid_request();
    fetch(32'h0000_0400, 32'h0800_0010);
    handshake(1'b1, 26'h10, 1'b0, 16'h0, 32'h0000_0040);
    #2 reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || pc_out !== 32'h0 || instr !== 32'h0)
      $display("FAIL reset_async: req=%b pc_out=%h instr=%h want 0 0 0", imem_req, pc_out, instr);
    else passed++;
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    reset    = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
      $display("FAIL reset_restart: req=%b addr=%h valid=%b want 1 00000000 0",
               imem_req, imem_addr, instr_valid);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    fetch(32'h0000_0000, 32'h1000_FFFE);
    handshake(1'b0, 26'h0, 1'b1, 16'hFFFE, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0000);
    total++;
    if (pc_plus4 !== 32'h0)
      $display("FAIL wrap_pc_plus4: got %h want 00000000", pc_plus4);
    else passed++;
    handshake(1'b0, 26'h0, 1'b0, 16'h0, 32'h0000_0000);
  endtask

  task automatic test_halt();
    fetch(32'h0000_0000, 32'hFC00_0000);
    total++;
    if (op !== 6'b111111 || halted !== 1'b0)
      $display("FAIL halt_op: op=%b halted=%b want 111111 0", op, halted);
    else passed++;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'h8C00_0000;
      @(negedge clk);
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'hFC00_0000)
        $display("FAIL halt_hold[%0d]: halted=%b req=%b valid=%b instr=%h want 1 0 0 fc000000",
                 i, halted, imem_req, instr_valid, instr);
      else passed++;
    end
    imem_ack = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    instr_ready   = 1'b0;
    jump          = 1'b0;
    jump_index    = '0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_branch_forward();
    test_jump();
    test_branch_back();
    test_reset_mid_request();
    test_wrap();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
